// File: rtl/cell_life_pkg.sv
// Shared constants, FSM state type and cell addressing for the cell life engine.
package cell_life_pkg;

    localparam int GRID_DIM     = 16;
    localparam int LOAD_CYCLES  = 257;
    localparam int WRITE_CYCLES = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_DONE
    } state_t;

    // idx is {y, x}, so ascending idx walks the grid row-major.
    function automatic logic [31:0] cell_addr(input logic [31:0] base, input logic [7:0] idx);
        return base + {22'h0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/cell_life_engine_if.sv
// Cell memory bus: one read port with one-cycle latency, one write port.
interface cell_life_engine_if;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        mem_wr_ena;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;

    modport master (
        output mem_rd_addr,
        input  mem_rd_data,
        output mem_wr_ena,
        output mem_wr_addr,
        output mem_wr_data
    );

    modport slave (
        input  mem_rd_addr,
        output mem_rd_data,
        input  mem_wr_ena,
        input  mem_wr_addr,
        input  mem_wr_data
    );
endinterface

// File: rtl/life_cell_rule.sv
// B3/S23 rule for a single cell: counts eight neighbour bits and decides survival/birth.
module life_cell_rule (
    input  logic       center,
    input  logic [7:0] nbrs,
    output logic       alive
);
    logic [3:0] count;

    always_comb begin
        count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, nbrs[i]};
        end
        alive = (count == 4'd3) || (center && (count == 4'd2));
    end
endmodule

// File: rtl/cell_life_engine.sv
// Game-of-life engine over a 16x16 word-per-cell grid in external memory: snapshot the
// grid into a local shadow, then rewrite every cell with its next state.
module cell_life_engine
    import cell_life_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] ALIVE_WORD = 32'h00FF_FFFF,
    parameter logic [31:0] DEAD_WORD  = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               step,
    input  logic               core_ena,
    input  logic               wrap,
    cell_life_engine_if.master mem,
    output logic               busy,
    output logic               done,
    output logic [31:0]        generation
);
    localparam logic [8:0]        LOAD_LAST  = 9'(LOAD_CYCLES - 1);
    localparam logic [8:0]        WRITE_LAST = 9'(WRITE_CYCLES - 1);
    localparam logic signed [5:0] EDGE       = 6'(GRID_DIM - 1);
    localparam logic signed [1:0] DM         = -2'sd1;
    localparam logic signed [1:0] DZ         = 2'sd0;
    localparam logic signed [1:0] DP         = 2'sd1;

    state_t       state, state_nxt;
    logic [8:0]   cnt;
    logic [7:0]   cap_idx;
    logic [7:0]   nidx;
    logic         wrap_q;
    logic [255:0] shadow;
    logic [255:0] grid;
    logic [7:0]   nbrs;
    logic         center;
    logic         alive_nxt;
    logic         unused_rd_bits;

    assign unused_rd_bits = ^mem.mem_rd_data[31:1];

    function automatic logic nbr_bit(input logic [255:0] g, input logic [7:0] idx,
                                     input logic signed [1:0] dx, input logic signed [1:0] dy,
                                     input logic wrap_en);
        logic signed [5:0] nx;
        logic signed [5:0] ny;
        nx = $signed({2'b00, idx[3:0]}) + 6'(dx);
        ny = $signed({2'b00, idx[7:4]}) + 6'(dy);
        if (!wrap_en && (nx < 6'sd0 || ny < 6'sd0 || nx > EDGE || ny > EDGE))
            return 1'b0;
        // Keeping only the low nibble gives modulo-16 wrap for the toroidal case.
        return g[{ny[3:0], nx[3:0]}];
    endfunction

    always_ff @(posedge clk) begin
        if (rstb) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (step && core_ena) state_nxt = ST_LOAD;
            ST_LOAD:  if (cnt == LOAD_LAST) state_nxt = ST_WRITE;
            ST_WRITE: if (cnt == WRITE_LAST) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            cnt <= 9'd0;
        end else begin
            case (state)
                ST_LOAD:  cnt <= (cnt == LOAD_LAST) ? 9'd0 : cnt + 9'd1;
                ST_WRITE: cnt <= cnt + 9'd1;
                default:  cnt <= 9'd0;
            endcase
        end
    end

    // Read data lags its address by one cycle, so cycle k captures cell k-1.
    assign cap_idx = cnt[7:0] - 8'd1;

    always_ff @(posedge clk) begin
        if (state == ST_LOAD && cnt != 9'd0)
            shadow[cap_idx] <= mem.mem_rd_data[0];
        if (state == ST_IDLE && state_nxt == ST_LOAD)
            wrap_q <= wrap;
    end

    // Cell 255 arrives on the same edge that launches the first write; forward it.
    always_comb begin
        grid = shadow;
        if (state == ST_LOAD)
            grid[255] = mem.mem_rd_data[0];
    end

    assign nidx   = (state == ST_WRITE) ? cnt[7:0] + 8'd1 : 8'd0;
    assign center = grid[nidx];

    assign nbrs[0] = nbr_bit(grid, nidx, DM, DM, wrap_q);
    assign nbrs[1] = nbr_bit(grid, nidx, DZ, DM, wrap_q);
    assign nbrs[2] = nbr_bit(grid, nidx, DP, DM, wrap_q);
    assign nbrs[3] = nbr_bit(grid, nidx, DM, DZ, wrap_q);
    assign nbrs[4] = nbr_bit(grid, nidx, DP, DZ, wrap_q);
    assign nbrs[5] = nbr_bit(grid, nidx, DM, DP, wrap_q);
    assign nbrs[6] = nbr_bit(grid, nidx, DZ, DP, wrap_q);
    assign nbrs[7] = nbr_bit(grid, nidx, DP, DP, wrap_q);

    life_cell_rule u_rule (
        .center (center),
        .nbrs   (nbrs),
        .alive  (alive_nxt)
    );

    always_ff @(posedge clk) begin
        if (rstb) begin
            mem.mem_wr_ena  <= 1'b0;
            mem.mem_wr_addr <= 32'h0;
            mem.mem_wr_data <= 32'h0;
            generation      <= 32'h0;
        end else begin
            mem.mem_wr_ena <= (state_nxt == ST_WRITE);
            if (state_nxt == ST_WRITE) begin
                mem.mem_wr_addr <= cell_addr(BASE_ADDR, nidx);
                mem.mem_wr_data <= alive_nxt ? ALIVE_WORD : DEAD_WORD;
            end
            if (state == ST_WRITE && state_nxt == ST_DONE)
                generation <= generation + 32'd1;
        end
    end

    assign mem.mem_rd_addr = (state == ST_LOAD && !cnt[8]) ? cell_addr(BASE_ADDR, cnt[7:0])
                                                           : BASE_ADDR;
    assign busy = (state == ST_LOAD) || (state == ST_WRITE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_cell_life_engine.sv
// Bench for cell_life_engine: memory model, cycle-level behavioural reference, directed and random generations.
module tb_cell_life_engine;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] ALIVE = 32'h00FF_FFFF;
    localparam logic [31:0] DEAD  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstb = 1'b1;
    logic        step = 1'b0;
    logic        core_ena = 1'b0;
    logic        wrap = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] generation;

    cell_life_engine_if mif ();

    cell_life_engine #(
        .BASE_ADDR  (BASE),
        .ALIVE_WORD (ALIVE),
        .DEAD_WORD  (DEAD)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .step       (step),
        .core_ena   (core_ena),
        .wrap       (wrap),
        .mem        (mif),
        .busy       (busy),
        .done       (done),
        .generation (generation)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_words [256];
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          alive_wr_cnt = 0;
    int          done_cnt = 0;
    logic        s_rst, s_step, s_ena, s_wrap;
    int          phase = -1;
    bit          started = 0;
    logic [31:0] exp_gen = 32'h0;
    bit          exp_next [256];

    function automatic logic [7:0] a2i(input logic [31:0] a);
        logic [31:0] d;
        d = (a - BASE) >> 2;
        return d[7:0];
    endfunction

    function automatic int count_alive();
        int n;
        n = 0;
        for (int i = 0; i < 256; i++) if (mem_words[i] === ALIVE) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Next generation straight from the life rules on a 2-D view of memory.
    task automatic model_next(input logic w);
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                int n;
                bit self;
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int nx, ny;
                        nx = x + dx;
                        ny = y + dy;
                        if (dx != 0 || dy != 0) begin
                            if (w) begin
                                nx = (nx + 16) % 16;
                                ny = (ny + 16) % 16;
                                n += int'(mem_words[ny * 16 + nx][0]);
                            end else if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16) begin
                                n += int'(mem_words[ny * 16 + nx][0]);
                            end
                        end
                    end
                end
                self = mem_words[y * 16 + x][0];
                exp_next[y * 16 + x] = (n == 3) || (self && n == 2);
            end
        end
    endtask

    // Memory: registered read data, writes applied at the strobe edge.
    always @(posedge clk) begin
        mif.mem_rd_data <= mem_words[a2i(mif.mem_rd_addr)];
        if (mif.mem_wr_ena === 1'b1) begin
            mem_words[a2i(mif.mem_wr_addr)] = mif.mem_wr_data;
            wr_cnt++;
            if (mif.mem_wr_data === ALIVE) alive_wr_cnt++;
        end
        s_rst  <= rstb;
        s_step <= step;
        s_ena  <= core_ena;
        s_wrap <= wrap;
    end

    // phase = cycles since the accepted step edge; -1 while idle.
    always @(negedge clk) begin
        logic e_wr;
        if (s_rst === 1'b1) begin
            phase   = -1;
            exp_gen = 32'h0;
            started = 1;
        end else if (started) begin
            if (phase >= 0) begin
                phase++;
                if (phase == 513) exp_gen = exp_gen + 32'd1;
                if (phase > 513) phase = -1;
            end else if (s_step === 1'b1 && s_ena === 1'b1) begin
                phase = 0;
                model_next(s_wrap);
            end
        end
        if (started) begin
            chk("rd_addr", mif.mem_rd_addr,
                (phase >= 0 && phase <= 255) ? BASE + 32'(phase) * 4 : BASE);
            chk("busy", 32'(busy), 32'(phase >= 0 && phase <= 512));
            chk("done", 32'(done), 32'(phase == 513));
            chk("generation", generation, exp_gen);
            e_wr = (phase >= 257 && phase <= 512);
            chk("wr_ena", 32'(mif.mem_wr_ena), 32'(e_wr));
            if (e_wr) begin
                chk("wr_addr", mif.mem_wr_addr, BASE + 32'(phase - 257) * 4);
                chk("wr_data", mif.mem_wr_data, exp_next[phase - 257] ? ALIVE : DEAD);
            end
            if (s_rst === 1'b1) begin
                chk("rst_wr_addr", mif.mem_wr_addr, 32'h0);
                chk("rst_wr_data", mif.mem_wr_data, 32'h0);
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    // mode 0: quiet; 1: extra steps at E0+100/E0+400 and core_ena drop; 2: random noise.
    task automatic run_gen(input logic w, input int mode, output int lat);
        wrap = w;
        core_ena = 1'b1;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wrap = ~w;
        lat = 0;
        while (done !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
            step = 1'b0;
            if (done !== 1'b1) begin
                if (mode == 1) begin
                    step = (lat == 99 || lat == 399);
                    if (lat == 199) core_ena = 1'b0;
                end else if (mode == 2) begin
                    step = 1'($urandom_range(0, 1));
                    core_ena = 1'($urandom_range(0, 1));
                end
            end
        end
        step = 1'b0;
        core_ena = 1'b0;
        chk("done_seen", 32'(done), 32'h1);
        @(negedge clk);
    endtask

    initial begin
        int lat, b_wr, b_alive, b_done;
        for (int i = 0; i < 256; i++) mem_words[i] = DEAD;
        repeat (3) @(negedge clk);
        chk("reset_generation", generation, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_wr_ena", 32'(mif.mem_wr_ena), 32'h0);
        chk("reset_rd_addr", mif.mem_rd_addr, BASE);
        rstb = 1'b0;
        @(negedge clk);

        // Blinker, dead border, with ignored steps and core_ena drop mid-run.
        mem_words[8'h67] = ALIVE;
        mem_words[8'h77] = ALIVE;
        mem_words[8'h87] = ALIVE;
        b_wr = wr_cnt; b_alive = alive_wr_cnt; b_done = done_cnt;
        run_gen(1'b0, 1, lat);
        chk("blinker_latency", lat, 513);
        chk("blinker_done_pulses", done_cnt - b_done, 1);
        chk("blinker_generation", generation, 32'd1);
        chk("blinker_writes", wr_cnt - b_wr, 256);
        chk("blinker_alive_writes", alive_wr_cnt - b_alive, 3);
        chk("blinker_1d8", mem_words[8'h76], ALIVE);
        chk("blinker_1dc", mem_words[8'h77], ALIVE);
        chk("blinker_1e0", mem_words[8'h78], ALIVE);
        chk("blinker_live_total", count_alive(), 3);

        // Four corners: a block on the torus, isolated cells with a dead border.
        for (int i = 0; i < 256; i++) mem_words[i] = DEAD;
        mem_words[0] = ALIVE; mem_words[15] = ALIVE; mem_words[240] = ALIVE; mem_words[255] = ALIVE;
        run_gen(1'b1, 0, lat);
        chk("corner_wrap_live_total", count_alive(), 4);
        chk("corner_wrap_3fc", mem_words[255], ALIVE);
        chk("corner_wrap_000", mem_words[0], ALIVE);
        run_gen(1'b0, 0, lat);
        chk("corner_nowrap_live_total", count_alive(), 0);
        chk("corner_generation", generation, 32'd3);

        // Only bit0 of read data counts.
        for (int i = 0; i < 256; i++) mem_words[i] = 32'hFFFF_FFFE;
        b_wr = wr_cnt; b_alive = alive_wr_cnt;
        run_gen(1'b1, 2, lat);
        chk("bit0_writes", wr_cnt - b_wr, 256);
        chk("bit0_alive_writes", alive_wr_cnt - b_alive, 0);
        chk("bit0_dead_word", mem_words[8'h55], DEAD);

        // Reset at E0+300 aborts after 43 writes.
        for (int i = 0; i < 256; i++) mem_words[i] = $urandom;
        b_wr = wr_cnt;
        wrap = 1'b1; core_ena = 1'b1; step = 1'b1;
        @(negedge clk);
        step = 1'b0; core_ena = 1'b0;
        repeat (299) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_wr_ena", 32'(mif.mem_wr_ena), 32'h0);
        chk("abort_generation", generation, 32'h0);
        @(negedge clk);
        rstb = 1'b0;
        chk("abort_writes", wr_cnt - b_wr, 43);
        repeat (600) @(negedge clk);
        chk("abort_no_more_writes", wr_cnt - b_wr, 43);

        // Random grids, some chained from the previous result.
        for (int g = 0; g < 6; g++) begin
            if (g % 2 == 0) for (int i = 0; i < 256; i++) mem_words[i] = $urandom;
            run_gen(1'($urandom_range(0, 1)), 2, lat);
            chk("random_latency", lat, 513);
        end
        chk("final_generation", generation, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cell_life_engine.md
CELL_LIFE_ENGINE -- requirements
Module: cell_life_engine

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of cell (0,0).
REQ-002 SHALL have parameter ALIVE_WORD, default 32'h00FF_FFFF: word written for a live cell (bit0 SHALL be 1).
REQ-003 SHALL have parameter DEAD_WORD, default 32'h0000_0000: word written for a dead cell (bit0 SHALL be 0).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rstb  input  1  reset, synchronous, active-high (1 = reset).
REQ-006 step  input  1  request one generation; sampled each edge.
REQ-007 core_ena  input  1  global enable; step is ignored while 0.
REQ-008 wrap  input  1  1 = toroidal grid, 0 = dead border.
REQ-009 mem_rd_addr  output  32  cell read byte address.
REQ-010 mem_rd_data  input  32  read data, valid one cycle after mem_rd_addr.
REQ-011 mem_wr_ena  output  1  write strobe.
REQ-012 mem_wr_addr  output  32  write byte address.
REQ-013 mem_wr_data  output  32  write data.
REQ-014 busy  output  1  high in LOAD and WRITE.
REQ-015 done  output  1  one-cycle pulse when a generation completes.
REQ-016 generation  output  32  count of completed generations.

Function
REQ-017 Grid: 16x16 cells; cell (x,y) at BASE_ADDR + {22'h0, y[3:0], x[3:0], 2'b00}, 32-bit wrap-around add; only bit0 of mem_rd_data SHALL be used (1 = alive).
REQ-018 FSM states: IDLE, LOAD, WRITE, DONE; IDLE->LOAD on step & core_ena; LOAD->WRITE after 257 cycles; WRITE->DONE after 256 cycles; DONE->IDLE after 1 cycle.
REQ-019 On the IDLE->LOAD edge, wrap SHALL be captured and held for the generation.
REQ-020 LOAD: issue reads for cells 0..255 row-major (y outer, x inner), one per cycle, then one drain cycle; each word's bit0 captured into a 256-bit shadow one cycle after its address.
REQ-021 WRITE: one registered write per cycle, row-major, mem_wr_ena=1, mem_wr_data = ALIVE_WORD or DEAD_WORD from the next state computed from the shadow only.
REQ-022 Rule B3/S23: dead cell with exactly 3 live neighbours -> alive; live cell with 2 or 3 -> alive; otherwise dead; neighbour count 0..8 over 4-bit arithmetic.
REQ-023 wrap=1: neighbour coordinates modulo 16; wrap=0: out-of-grid neighbours count as dead.
REQ-024 done=1 exactly in the DONE cycle, i.e. the cycle after edge E0+513 when E0 is the step-sampling edge; generation increments by 1 in the same cycle, wrapping 32'hFFFF_FFFF->0.
REQ-025 step while not IDLE SHALL be ignored (no queuing); core_ena deasserted mid-generation SHALL NOT abort it.
REQ-026 mem_wr_ena SHALL be 0 in every state except WRITE; mem_rd_addr SHALL equal BASE_ADDR outside LOAD.

Reset
REQ-027 While rstb=1: state IDLE, busy=0, done=0, mem_wr_ena=0, mem_wr_addr=0, mem_wr_data=0, mem_rd_addr=BASE_ADDR, generation=0; shadow contents don't-care.
REQ-028 Reset asserted mid-LOAD or mid-WRITE SHALL abort at the next edge with no further writes; partially written grid is left as is.

Structure
REQ-029 Shared package cell_life_pkg SHALL hold GRID_DIM=16, LOAD_CYCLES=257, WRITE_CYCLES=256, the state enum and the cell-address function.
REQ-030 Neighbour count plus rule SHALL be one combinational sub-module, life_cell_rule (9 inputs -> next alive).

Verification
REQ-031 Blinker, wrap=0: live at 0x19C,0x1DC,0x21C -> after one step, writes ALIVE_WORD only to 0x1D8,0x1DC,0x1E0; all other 253 writes are DEAD_WORD.
REQ-032 Corners 0x000,0x03C,0x3C0,0x3FC live: wrap=1 -> all four stay alive (block); wrap=0 -> all four written DEAD_WORD.
REQ-033 Timing: step at E0 -> reads at addresses 0x000..0x3FC on 256 consecutive cycles, first write 0x000 after E0+257, done one cycle only after E0+513, generation 0->1.
REQ-034 step pulsed again at E0+100 and E0+400 -> ignored; exactly one done pulse, generation=1.
REQ-035 rstb=1 at E0+300 -> mem_wr_ena=0, busy=0, generation=0 after the next edge; no further writes.
REQ-036 mem_rd_data=32'hFFFF_FFFE for every cell -> all cells treated dead; all 256 writes DEAD_WORD.
